// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch responder: FSM states, NOP word and buffer entry.
// Entry count depends on FETCH_PREFETCH_EN (two entries when defined, one otherwise).
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INSTRUCTION_NOP = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] data;
  } fetch_entry_t;

`ifdef FETCH_PREFETCH_EN
  localparam int NUM_ENTRIES = 2;
`else
  localparam int NUM_ENTRIES = 1;
`endif

  // True when the byte address lies inside the window reachable by the memory port.
  function automatic logic addr_in_range(input logic [31:0] byte_addr, input int aw);
    return (byte_addr >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/fetch_buffer_entry.sv
// One tagged instruction-buffer entry: write port, demand hit compare and, under
// FETCH_PREFETCH_EN, a second compare used to check whether a prefetch target is resident.
module fetch_buffer_entry
  import fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_write_en,
  input  logic [31:0] i_write_tag,
  input  logic [31:0] i_write_data,
  input  logic [31:0] i_lookup_addr,
`ifdef FETCH_PREFETCH_EN
  input  logic [31:0] i_probe_addr,
  output logic        o_probe_hit,
`endif
  output logic        o_hit,
  output logic [31:0] o_data
);

  fetch_entry_t r_entry;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_entry <= '0;
    end else if (i_write_en) begin
      r_entry.valid <= 1'b1;
      r_entry.tag   <= i_write_tag;
      r_entry.data  <= i_write_data;
    end
  end

  assign o_hit  = r_entry.valid && (r_entry.tag == i_lookup_addr);
  assign o_data = r_entry.data;

`ifdef FETCH_PREFETCH_EN
  assign o_probe_hit = r_entry.valid && (r_entry.tag == i_probe_addr);
`endif

endmodule

// File: rtl/instruction_fetch_responder.sv
// Responder side of the IF interface: serves words from a small tagged buffer, fetching misses
// over a req/ack memory port. FETCH_PREFETCH_EN adds a second entry and sequential prefetch.
module instruction_fetch_responder
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_enable,
  input  logic [31:0]           address,
  output logic [31:0]           instruction,
  output logic                  instruction_valid,
  output logic                  instruction_misaligned,
  output logic                  stall_request,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [31:0]           mem_read_data,
  input  logic                  mem_ack
);

  fetch_state_t          r_state;
  logic [31:0]           r_req_addr;
  logic                  r_mem_read_enable;
  logic [ADDR_WIDTH-1:0] r_mem_address;

  logic [NUM_ENTRIES-1:0] w_entry_hit;
  logic [NUM_ENTRIES-1:0] w_write_en;
  logic [31:0]            w_entry_data [NUM_ENTRIES];

  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_hit;
  logic        w_bypass;
  logic        w_fill;
  logic        w_stall;
  logic        w_decide;
  logic        w_issue;
  logic [31:0] w_issue_addr;
  logic [31:0] w_hit_data;

`ifdef FETCH_PREFETCH_EN
  logic                   r_req_pf;
  logic                   r_req_slot;
  logic                   w_issue_pf;
  logic                   w_issue_slot;
  logic                   w_pf_src;
  logic                   w_src_slot;
  logic [31:0]            w_pf_addr;
  logic [NUM_ENTRIES-1:0] w_probe_hit;
  logic [NUM_ENTRIES-1:0] w_eff_probe;
`endif

  assign w_fill         = (r_state == WAIT) && mem_ack;
  assign w_misaligned   = chip_enable && (address[1:0] != 2'b00);
  assign w_out_of_range = !addr_in_range(address, ADDR_WIDTH);

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
`ifdef FETCH_PREFETCH_EN
      assign w_write_en[gi]  = w_fill && (r_req_slot == 1'(gi));
      // The slot being filled this cycle already counts as holding the incoming tag.
      assign w_eff_probe[gi] = (w_fill && (r_req_slot == 1'(gi))) ?
                               (r_req_addr == w_pf_addr) : w_probe_hit[gi];
`else
      assign w_write_en[gi]  = w_fill;
`endif
      fetch_buffer_entry u_entry (
        .clock         (clock),
        .reset         (reset),
        .i_write_en    (w_write_en[gi]),
        .i_write_tag   (r_req_addr),
        .i_write_data  (mem_read_data),
        .i_lookup_addr (address),
`ifdef FETCH_PREFETCH_EN
        .i_probe_addr  (w_pf_addr),
        .o_probe_hit   (w_probe_hit[gi]),
`endif
        .o_hit         (w_entry_hit[gi]),
        .o_data        (w_entry_data[gi])
      );
    end
  endgenerate

`ifdef FETCH_PREFETCH_EN
  // A prefetch completing for the current PC is forwarded so a primed stream never stalls.
  assign w_bypass = r_req_pf && w_fill && (address == r_req_addr);
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_hit_data = INSTRUCTION_NOP;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_entry_hit[i]) begin
        w_hit_data = w_entry_data[i];
      end
    end
    if (w_bypass) begin
      w_hit_data = mem_read_data;
    end
  end

  assign w_hit   = chip_enable && ((|w_entry_hit) || w_bypass);
  assign w_stall = chip_enable && !w_hit && !w_misaligned && !w_out_of_range;

  assign instruction            = w_hit ? w_hit_data : INSTRUCTION_NOP;
  assign instruction_valid      = w_hit || (chip_enable && w_out_of_range && !w_misaligned);
  assign instruction_misaligned = w_misaligned;
  assign stall_request          = w_stall;
  assign mem_read_enable        = r_mem_read_enable;
  assign mem_address            = r_mem_address;

`ifdef FETCH_PREFETCH_EN
  // Requests are chosen in IDLE or back-to-back when a prefetch completes; demand wins.
  assign w_decide   = (r_state == IDLE) || (w_fill && r_req_pf);
  assign w_pf_addr  = address + 32'd4;
  assign w_pf_src   = chip_enable && ((r_state == IDLE) ? (|w_entry_hit) : w_bypass);
  assign w_src_slot = (r_state == IDLE) ? w_entry_hit[1] : r_req_slot;

  always_comb begin
    w_issue      = 1'b0;
    w_issue_addr = address;
    w_issue_pf   = 1'b0;
    w_issue_slot = 1'b0;
    if (w_decide) begin
      if (w_stall) begin
        w_issue = 1'b1;
      end else if (w_pf_src && !(|w_eff_probe) && addr_in_range(w_pf_addr, ADDR_WIDTH)) begin
        w_issue      = 1'b1;
        w_issue_addr = w_pf_addr;
        w_issue_pf   = 1'b1;
        w_issue_slot = !w_src_slot;
      end
    end
  end
`else
  assign w_decide     = (r_state == IDLE);
  assign w_issue      = w_decide && w_stall;
  assign w_issue_addr = address;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state           <= IDLE;
      r_req_addr        <= '0;
      r_mem_read_enable <= 1'b0;
      r_mem_address     <= '0;
`ifdef FETCH_PREFETCH_EN
      r_req_pf          <= 1'b0;
      r_req_slot        <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, WAIT: begin
          if (w_issue) begin
            r_state           <= WAIT;
            r_req_addr        <= w_issue_addr;
            r_mem_read_enable <= 1'b1;
            r_mem_address     <= w_issue_addr[ADDR_WIDTH+1:2];
`ifdef FETCH_PREFETCH_EN
            r_req_pf          <= w_issue_pf;
            r_req_slot        <= w_issue_slot;
`endif
          end else if (w_fill) begin
            // Completed request with nothing queued behind it; stray acks in IDLE never get here.
            r_state           <= IDLE;
            r_mem_read_enable <= 1'b0;
          end
        end
        default: begin
          r_state           <= IDLE;
          r_mem_read_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
